// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM stage: bus widths, field offsets, load opcodes, FSM states.
package mem_stage_lsu_pkg;

    localparam int ES_BUS_W = 76;
    localparam int WS_BUS_W = 70;

    // es_to_ms_bus = {mem_op, addr_lo, res_from_mem, gr_we, dest, result, pc}
    localparam int ES_PC_LSB   = 0;
    localparam int ES_RES_LSB  = 32;
    localparam int ES_DEST_LSB = 64;
    localparam int ES_GRWE_BIT = 69;
    localparam int ES_RFM_BIT  = 70;
    localparam int ES_ALO_LSB  = 71;
    localparam int ES_OP_LSB   = 73;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_H  = 3'b010,
        LD_BU = 3'b011,
        LD_HU = 3'b100
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2
    } ms_state_e;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational sub-word selection and sign/zero extension of SRAM read data.
module mem_stage_lsu_load_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  mem_op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        result_o = rdata_i;
        case (mem_op_i)
            LD_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
            LD_H:    result_o = {{16{half_sel[15]}}, half_sel};
            LD_BU:   result_o = {24'd0, byte_sel};
            LD_HU:   result_o = {16'd0, half_sel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: holds one EXE instruction, waits for load data, hands 70-bit bus to WB (valid/allowin).
// Non-load 1 cycle, load 1 + response wait; WB backpressure parks load data in rdata_buf. Option: MS_PERF_CNT_EN.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                es_to_ms_valid,
    input  logic [ES_BUS_W-1:0] es_to_ms_bus,
    output logic                ms_allowin,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    input  logic                ws_allowin,
    output logic                ms_to_ws_valid,
    output logic [WS_BUS_W-1:0] ms_to_ws_bus,
    output logic                ms_fwd_valid,
    output logic [4:0]          ms_fwd_dest,
    output logic [31:0]         ms_fwd_data,
    output logic                ms_load_busy,
    output logic                ms_resp_err
`ifdef MS_PERF_CNT_EN
    ,
    output logic [31:0]         ms_stall_cnt,
    output logic [31:0]         ms_load_cnt
`endif
);

    ms_state_e           state_q, state_d;
    logic [ES_BUS_W-1:0] bus_q, bus_d;
    logic [31:0]         rdata_buf_q, rdata_buf_d;
    logic                resp_err_q, resp_err_d;

    logic        res_from_mem, gr_we, ready_go, accept, retire;
    logic [4:0]  dest;
    logic [31:0] result, pc, aligned, final_result;

    assign res_from_mem = bus_q[ES_RFM_BIT];
    assign gr_we        = bus_q[ES_GRWE_BIT];
    assign dest         = bus_q[ES_DEST_LSB +: 5];
    assign result       = bus_q[ES_RES_LSB +: 32];
    assign pc           = bus_q[ES_PC_LSB +: 32];

    mem_stage_lsu_load_align u_align (
        .mem_op_i  (bus_q[ES_OP_LSB +: 3]),
        .addr_lo_i (bus_q[ES_ALO_LSB +: 2]),
        .rdata_i   (data_sram_rdata),
        .result_o  (aligned)
    );

    assign ready_go   = (state_q == ST_DONE) || (state_q == ST_WAIT && data_sram_data_ok);
    // Held low during reset so EXE cannot hand over an instruction that would be discarded.
    assign ms_allowin = !reset && ((state_q == ST_EMPTY) || (ready_go && ws_allowin));
    assign accept     = es_to_ms_valid && ms_allowin;
    assign retire     = ready_go && ws_allowin;

    always_comb begin
        final_result = result;
        if (state_q == ST_WAIT)
            final_result = aligned;
        else if (state_q == ST_DONE && res_from_mem)
            final_result = rdata_buf_q;
    end

    assign ms_to_ws_valid = ready_go;
    assign ms_to_ws_bus   = {gr_we, dest, final_result, pc};
    assign ms_fwd_valid   = (state_q != ST_EMPTY) && gr_we && (dest != 5'd0);
    assign ms_fwd_dest    = dest;
    assign ms_fwd_data    = final_result;
    assign ms_load_busy   = (state_q == ST_WAIT) && !data_sram_data_ok;
    assign ms_resp_err    = resp_err_q;

    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        rdata_buf_d = rdata_buf_q;
        resp_err_d  = resp_err_q || (data_sram_data_ok && state_q != ST_WAIT);
        if (accept) begin
            bus_d   = es_to_ms_bus;
            state_d = es_to_ms_bus[ES_RFM_BIT] ? ST_WAIT : ST_DONE;
        end else if (retire) begin
            state_d = ST_EMPTY;
        end else if (state_q == ST_WAIT && data_sram_data_ok) begin
            rdata_buf_d = aligned;
            state_d     = ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            bus_q       <= '0;
            rdata_buf_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            rdata_buf_q <= rdata_buf_d;
            resp_err_q  <= resp_err_d;
        end
    end

`ifdef MS_PERF_CNT_EN
    logic [31:0] stall_cnt_q, load_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            load_cnt_q  <= '0;
        end else begin
            if (ms_load_busy)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (retire && res_from_mem)
                load_cnt_q <= load_cnt_q + 32'd1;
        end
    end

    assign ms_stall_cnt = stall_cnt_q;
    assign ms_load_cnt  = load_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with hand-computed expectations.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid;
    logic [75:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        ms_fwd_valid;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_data;
    logic        ms_load_busy;
    logic        ms_resp_err;
`ifdef MS_PERF_CNT_EN
    logic [31:0] ms_stall_cnt;
    logic [31:0] ms_load_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_fwd_valid      (ms_fwd_valid),
        .ms_fwd_dest       (ms_fwd_dest),
        .ms_fwd_data       (ms_fwd_data),
        .ms_load_busy      (ms_load_busy),
        .ms_resp_err       (ms_resp_err)
`ifdef MS_PERF_CNT_EN
        ,
        .ms_stall_cnt      (ms_stall_cnt),
        .ms_load_cnt       (ms_load_cnt)
`endif
    );

    function automatic logic [75:0] mk_es(input logic [2:0] op, input logic [1:0] alo,
                                          input logic rfm, input logic we, input logic [4:0] dst,
                                          input logic [31:0] res, input logic [31:0] pc);
        return {op, alo, rfm, we, dst, res, pc};
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0; ws_allowin = 1'b1;
        tick(); tick();
        chk("rst_allowin", 70'(ms_allowin), 70'd0);
        chk("rst_valid",   70'(ms_to_ws_valid), 70'd0);
        chk("rst_bus",     ms_to_ws_bus, 70'd0);
        chk("rst_fwd",     70'({ms_fwd_valid, ms_fwd_dest, ms_fwd_data}), 70'd0);
        chk("rst_busy_err", 70'({ms_load_busy, ms_resp_err}), 70'd0);
        reset = 1'b0;
        tick();
        chk("idle_allowin", 70'(ms_allowin), 70'd1);

        // 1: plain ALU op
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(3'b000, 2'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_1000);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk("t1_valid", 70'(ms_to_ws_valid), 70'd1);
        chk("t1_bus",   ms_to_ws_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h0000_1000});
        chk("t1_fwd",   70'({ms_fwd_valid, ms_fwd_dest, ms_load_busy}), 70'({1'b1, 5'd5, 1'b0}));
        tick();
        chk("t1_gone",  70'(ms_to_ws_valid), 70'd0);

        // 2: ld.b at byte 3, response after three busy cycles
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(3'b001, 2'd3, 1'b1, 1'b1, 5'd6, 32'h0000_2003, 32'h0000_1004);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk("t2_busy1", 70'({ms_load_busy, ms_to_ws_valid}), 70'b10);
        tick();
        chk("t2_busy2", 70'(ms_load_busy), 70'd1);
        tick();
        chk("t2_busy3", 70'(ms_load_busy), 70'd1);
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_0000;
        #1;
        chk("t2_ldb_bus", ms_to_ws_bus, {1'b1, 5'd6, 32'hFFFF_FF80, 32'h0000_1004});
        chk("t2_ldb_vld", 70'({ms_to_ws_valid, ms_load_busy, ms_allowin}), 70'b101);
        tick();
        data_sram_data_ok = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(3'b011, 2'd3, 1'b1, 1'b1, 5'd7, 32'h0000_2003, 32'h0000_1008);
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1;
        #1;
        chk("t2_ldbu", 70'(ms_fwd_data), 70'h0000_0080);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("t2_gone", 70'(ms_to_ws_valid), 70'd0);

        // 3: ld.h at offset 2 under WB backpressure
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(3'b010, 2'd2, 1'b1, 1'b1, 5'd8, 32'h0000_3002, 32'h0000_100C);
        tick();
        es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_7FFF;
        #1;
        chk("t3_pass", 70'({ms_to_ws_valid, ms_allowin, ms_fwd_data}), {1'b1, 1'b0, 32'hFFFF_8001});
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t3_held1", ms_to_ws_bus, {1'b1, 5'd8, 32'hFFFF_8001, 32'h0000_100C});
        tick();
        chk("t3_held2", 70'({ms_to_ws_valid, ms_load_busy, ms_fwd_data}), {1'b1, 1'b0, 32'hFFFF_8001});
        ws_allowin = 1'b1;
        #1;
        chk("t3_release", 70'(ms_allowin), 70'd1);
        tick();
        chk("t3_gone", 70'({ms_to_ws_valid, ms_resp_err}), 70'd0);

        // 4: back-to-back non-loads, middle one writes r0
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(3'b000, 2'd0, 1'b0, 1'b1, 5'd9, 32'hAAAA_0001, 32'h0000_2000);
        tick();
        es_to_ms_bus = mk_es(3'b000, 2'd0, 1'b0, 1'b1, 5'd0, 32'hAAAA_0002, 32'h0000_2004);
        #1;
        chk("t4_a", ms_to_ws_bus, {1'b1, 5'd9, 32'hAAAA_0001, 32'h0000_2000});
        chk("t4_a_alw", 70'({ms_to_ws_valid, ms_allowin}), 70'b11);
        tick();
        es_to_ms_bus = mk_es(3'b000, 2'd0, 1'b0, 1'b0, 5'd3, 32'hAAAA_0003, 32'h0000_2008);
        #1;
        chk("t4_b", ms_to_ws_bus, {1'b1, 5'd0, 32'hAAAA_0002, 32'h0000_2004});
        chk("t4_b_fwd", 70'({ms_fwd_valid, ms_allowin}), 70'b01);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk("t4_c", ms_to_ws_bus, {1'b0, 5'd3, 32'hAAAA_0003, 32'h0000_2008});
        chk("t4_c_fwd", 70'({ms_to_ws_valid, ms_fwd_valid}), 70'b10);
        tick();
        chk("t4_gone", 70'(ms_to_ws_valid), 70'd0);

        // 5: stray response while empty
        data_sram_data_ok = 1'b1;
        #1;
        chk("t5_novalid", 70'({ms_to_ws_valid, ms_resp_err}), 70'b00);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("t5_err", 70'({ms_resp_err, ms_to_ws_valid}), 70'b10);
        tick(); tick();
        chk("t5_sticky", 70'(ms_resp_err), 70'd1);

        // 6: reset while a load waits
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(3'b000, 2'd0, 1'b1, 1'b1, 5'd4, 32'h0000_4000, 32'h0000_3000);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk("t6_busy", 70'(ms_load_busy), 70'd1);
        reset = 1'b1;
        tick();
        chk("t6_rst_bus", ms_to_ws_bus, 70'd0);
        chk("t6_rst_flags", 70'({ms_to_ws_valid, ms_load_busy, ms_resp_err, ms_fwd_valid, ms_allowin}), 70'd0);
        reset = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(3'b000, 2'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_3004);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk("t6_after", ms_to_ws_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h0000_3004});
        chk("t6_after_vld", 70'({ms_to_ws_valid, ms_load_busy, ms_resp_err}), 70'b100);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
